// File: rtl/spiral_pattern_gen_if.sv
// Video timing in / pixel colour out bundle shared between the VGA timing
// block (master) and the spiral pattern generator (slave).
interface spiral_pattern_gen_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       next_frame;
    logic [5:0] rgb;
    logic       rgb_active;

    modport master (output x, y, active, next_frame, input rgb, rgb_active);
    modport slave  (input x, y, active, next_frame, output rgb, rgb_active);
endinterface

// File: rtl/spiral_pattern_gen.sv
// Rotating spiral / pinwheel / rings pattern with frame-latched mode and
// direction, palette cycling and a two-stage registered pixel pipeline.
module spiral_pattern_gen #(
    parameter int CENTER_X     = 320,
    parameter int CENTER_Y     = 240,
    parameter int NUM_ARMS     = 6,
    parameter int RADIUS_SHIFT = 4,
    parameter int MIN_RADIUS   = 20,
    parameter int PAL_DIV_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pattern_enable,
    input  logic [2:0]           step_size,
    input  logic                 direction,
    input  logic [1:0]           mode,
    input  logic                 palette_cycle,
    spiral_pattern_gen_if.slave  vid
);
    localparam int FD_W = PAL_DIV_LOG2 + 1;
    localparam logic [FD_W-1:0] DIV_MAX = FD_W'((1 << PAL_DIV_LOG2) - 1);
    localparam logic signed [10:0] CX_S = 11'(CENTER_X);
    localparam logic signed [10:0] CY_S = 11'(CENTER_Y);
    localparam logic [2:0] LAST_ARM = 3'(NUM_ARMS - 1);

    localparam logic [1:0] MODE_SPIRAL  = 2'd0;
    localparam logic [1:0] MODE_REVERSE = 2'd1;
    localparam logic [1:0] MODE_PINWHL  = 2'd2;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic signed [10:0] c);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - c;
        return d[10] ? 10'(-d) : d[9:0];
    endfunction

    // slot < NUM_ARMS and palette_idx < NUM_ARMS, so one subtraction suffices
    function automatic logic [2:0] wrap_arms(input logic [3:0] s);
        return (s >= 4'(NUM_ARMS)) ? 3'(s - 4'(NUM_ARMS)) : s[2:0];
    endfunction

    function automatic logic [5:0] colour_lut(input logic [2:0] i);
        case (i)
            3'd0:    return 6'b010001;
            3'd1:    return 6'b100011;
            3'd2:    return 6'b111010;
            3'd3:    return 6'b001110;
            3'd4:    return 6'b011101;
            3'd5:    return 6'b101111;
            3'd6:    return 6'b110000;
            default: return 6'b000111;
        endcase
    endfunction

    logic [7:0]      rot_acc_q, rot_acc_d;
    logic [1:0]      mode_q, mode_d;
    logic            dir_q, dir_d;
    logic [FD_W-1:0] frame_div_q, frame_div_d;
    logic [2:0]      palette_idx_q, palette_idx_d;

    logic [10:0] radius_p1_q, radius_p1_d;
    logic [2:0]  sector_p1_q, sector_p1_d;
    logic        vld_p1_q, vld_p1_d;
    logic [5:0]  rgb_p2_q, rgb_p2_d;
    logic        vld_p2_q, vld_p2_d;

    logic [9:0] dx, dy;
    logic [5:0] offset, angle, rterm, phase;
    logic [2:0] slot;
    logic       in_arm;

    always_comb begin
        rot_acc_d     = rot_acc_q;
        mode_d        = mode_q;
        dir_d         = dir_q;
        frame_div_d   = frame_div_q;
        palette_idx_d = palette_idx_q;
        if (pattern_enable && vid.next_frame) begin
            rot_acc_d = dir_q ? rot_acc_q - {5'b0, step_size} : rot_acc_q + {5'b0, step_size};
            mode_d    = mode;
            dir_d     = direction;
            if (palette_cycle) begin
                if (frame_div_q == DIV_MAX) begin
                    frame_div_d   = '0;
                    palette_idx_d = (palette_idx_q == LAST_ARM) ? 3'd0 : palette_idx_q + 3'd1;
                end else begin
                    frame_div_d = frame_div_q + FD_W'(1);
                end
            end
        end
    end

    // Stage 1: distance from centre and octant
    always_comb begin
        dx          = abs_diff(vid.x, CX_S);
        dy          = abs_diff(vid.y, CY_S);
        radius_p1_d = {1'b0, dx} + {1'b0, dy};
        sector_p1_d = {vid.x >= 10'(CENTER_X), vid.y >= 10'(CENTER_Y), dx > dy};
        vld_p1_d    = vid.active;
    end

    // Stage 2: phase, arm membership and colour
    always_comb begin
        offset = rot_acc_q[7:2];
        angle  = {sector_p1_q, 3'b000} + offset;
        rterm  = 6'(radius_p1_q >> RADIUS_SHIFT);
        case (mode_q)
            MODE_SPIRAL:  phase = angle - rterm;
            MODE_REVERSE: phase = angle + rterm;
            MODE_PINWHL:  phase = angle;
            default:      phase = rterm + offset;
        endcase
        slot     = phase[5:3];
        in_arm   = !phase[2] && ({1'b0, slot} < 4'(NUM_ARMS)) && (radius_p1_q > 11'(MIN_RADIUS));
        rgb_p2_d = (pattern_enable && vld_p1_q && in_arm)
                   ? colour_lut(wrap_arms({1'b0, slot} + {1'b0, palette_idx_q})) : 6'b0;
        vld_p2_d = vld_p1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_acc_q     <= '0;
            mode_q        <= '0;
            dir_q         <= 1'b0;
            frame_div_q   <= '0;
            palette_idx_q <= '0;
            radius_p1_q   <= '0;
            sector_p1_q   <= '0;
            vld_p1_q      <= 1'b0;
            rgb_p2_q      <= '0;
            vld_p2_q      <= 1'b0;
        end else begin
            rot_acc_q     <= rot_acc_d;
            mode_q        <= mode_d;
            dir_q         <= dir_d;
            frame_div_q   <= frame_div_d;
            palette_idx_q <= palette_idx_d;
            radius_p1_q   <= radius_p1_d;
            sector_p1_q   <= sector_p1_d;
            vld_p1_q      <= vld_p1_d;
            rgb_p2_q      <= rgb_p2_d;
            vld_p2_q      <= vld_p2_d;
        end
    end

    assign vid.rgb        = rgb_p2_q;
    assign vid.rgb_active = vld_p2_q;
endmodule

// File: tb/tb_spiral_pattern_gen.sv
// Directed bench for spiral_pattern_gen: hand-computed colours at default parameters.
module tb_spiral_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pattern_enable = 1'b1;
    logic [2:0] step_size = 3'd0;
    logic       direction = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       palette_cycle = 1'b0;

    int vectors = 0;
    int errs    = 0;

    spiral_pattern_gen_if vif ();

    spiral_pattern_gen dut (
        .clk            (clk),
        .rst            (rst),
        .pattern_enable (pattern_enable),
        .step_size      (step_size),
        .direction      (direction),
        .mode           (mode),
        .palette_cycle  (palette_cycle),
        .vid            (vif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic pulse();
        vif.next_frame = 1'b1;
        tick();
        vif.next_frame = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic pixel(input int px, input int py);
        vif.x      = 10'(px);
        vif.y      = 10'(py);
        vif.active = 1'b1;
        settle();
    endtask

    task automatic chk_rgb(input string tag, input logic [5:0] exp);
        vectors++;
        assert (vif.rgb === exp)
        else begin
            errs++;
            $error("FAIL %s: rgb observed %b expected %b", tag, vif.rgb, exp);
        end
    endtask

    task automatic chk_act(input string tag, input logic exp);
        vectors++;
        assert (vif.rgb_active === exp)
        else begin
            errs++;
            $error("FAIL %s: rgb_active observed %b expected %b", tag, vif.rgb_active, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vif.x = 10'd320;
        vif.y = 10'd240;
        vif.active = 1'b0;
        vif.next_frame = 1'b0;
        #2 rst = 1'b1;
        tick();
        tick();
        chk_rgb("reset_rgb", 6'b0);
        chk_act("reset_act", 1'b0);
        rst = 1'b0;

        // Latency: black after one edge, colour after two
        vif.x = 10'd240; vif.y = 10'd240; vif.active = 1'b1;
        tick();
        chk_rgb("latency_1clk", 6'b0);
        tick();
        chk_rgb("spiral_240_240", 6'b111010);
        chk_act("spiral_active", 1'b1);

        step_size = 3'd4;
        pulse();
        settle();
        chk_rgb("step4_offset1", 6'b000000);

        // Mid-frame reset clears outputs at once, colour returns two clocks later
        do_reset();
        settle();
        chk_rgb("after_reset_colour", 6'b111010);
        rst = 1'b1;
        #1;
        chk_rgb("async_reset_rgb", 6'b0);
        chk_act("async_reset_act", 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_rgb("post_reset_1clk", 6'b0);
        tick();
        chk_rgb("post_reset_2clk", 6'b111010);

        // Direction latched at first pulse: +4 then -4 -> 0, third pulse -> 252
        direction = 1'b1;
        step_size = 3'd4;
        pulses(2);
        settle();
        chk_rgb("dir_rot0", 6'b111010);
        mode = 2'd2;
        pulse();
        settle();
        chk_rgb("dir_rot252_pinwheel", 6'b000000);
        pixel(320, 240);
        chk_rgb("radius0_black", 6'b0);

        // Pinwheel at offset 0
        do_reset();
        direction = 1'b0;
        step_size = 3'd0;
        mode = 2'd2;
        pulse();
        pixel(240, 240);
        chk_rgb("pinwheel_slot3", 6'b001110);
        mode = 2'd0;
        settle();
        chk_rgb("mode_no_frame_hold", 6'b001110);
        pixel(299, 240);
        chk_rgb("radius21_lit", 6'b001110);
        pixel(300, 240);
        chk_rgb("radius20_black", 6'b0);
        pixel(320, 300);
        chk_rgb("slot6_outside_arms", 6'b0);
        pixel(400, 200);
        chk_rgb("pinwheel_slot5", 6'b101111);

        // Radius 128 -> rterm 8 in each remaining mode
        mode = 2'd0;
        pulse();
        pixel(192, 240);
        chk_rgb("spiral_r128", 6'b111010);
        mode = 2'd1;
        pulse();
        settle();
        chk_rgb("reverse_r128", 6'b011101);
        mode = 2'd3;
        pulse();
        settle();
        chk_rgb("rings_r128", 6'b100011);

        // Palette cycling
        do_reset();
        mode = 2'd0;
        step_size = 3'd0;
        palette_cycle = 1'b1;
        pixel(240, 240);
        pulses(7);
        settle();
        chk_rgb("pal_7frames", 6'b111010);
        pulse();
        settle();
        chk_rgb("pal_8frames", 6'b001110);
        pulses(8);
        settle();
        chk_rgb("pal_16frames", 6'b011101);
        pulses(32);
        settle();
        chk_rgb("pal_48frames_wrap", 6'b111010);

        // Disabled: state holds, output black, rgb_active still tracks active
        pattern_enable = 1'b0;
        step_size = 3'd4;
        pulses(8);
        settle();
        chk_rgb("disabled_black", 6'b0);
        chk_act("disabled_active", 1'b1);
        pattern_enable = 1'b1;
        step_size = 3'd0;
        palette_cycle = 1'b0;
        settle();
        chk_rgb("reenabled_state_held", 6'b111010);
        vif.active = 1'b0;
        settle();
        chk_rgb("inactive_black", 6'b0);
        chk_act("inactive_act", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
